// File: rtl/demux8_deser.sv
// demux8_deser: serial-to-parallel byte collector.
// Each accepted serial bit is steered by a 3-bit index through a 1:8
// demux into one lane of an 8-bit collector. The eighth bit moves the
// assembled byte into an output holding register. That register is
// presented to the consumer with a valid/ready handshake.
module demux8_deser #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] lane_en,
   output logic [2:0] bit_count
);

   // collector state
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] coll_q, coll_d;

   // output holding register
   logic [7:0] obyte_q, obyte_d;
   logic       ovld_q, ovld_d;

   // decode helpers
   logic [2:0] idx;
   logic       last_bit;
   logic       accept;
   logic       complete;
   logic       out_take;
   logic [7:0] assembled;

   // Lane index, ready/accept decode and the one-hot demux select.
   // Only the completing bit stalls on an occupied output register;
   // the bits of a partial byte keep flowing.
   always_comb begin
      idx      = LSB_FIRST ? cnt_q : (3'd7 - cnt_q);
      last_bit = (cnt_q == 3'd7);
      in_ready = !flush && !(last_bit && ovld_q && !out_ready);
      accept   = in_valid && in_ready;
      complete = accept && last_bit;
      out_take = ovld_q && out_ready;
      lane_en  = accept ? (8'b1 << idx) : 8'b0;
   end

   // Next-state for the collector and the output register. The demux write
   // merges in_bit into the selected lane and holds every other lane.
   always_comb begin
      cnt_d     = cnt_q;
      coll_d    = coll_q;
      obyte_d   = obyte_q;
      ovld_d    = ovld_q;
      assembled = (coll_q & ~lane_en) | ({8{in_bit}} & lane_en);

      if (flush) begin
         // Drop the partial byte. in_ready is low here, so nothing is accepted.
         cnt_d  = 3'd0;
         coll_d = 8'd0;
      end else if (accept) begin
         if (last_bit) begin
            cnt_d  = 3'd0;
            coll_d = 8'd0;
         end else begin
            cnt_d  = cnt_q + 3'd1;
            coll_d = assembled;
         end
      end

      // A completion takes priority over a consume. When both happen in the
      // same cycle, the new byte replaces the old one with no bubble.
      if (complete) begin
         obyte_d = assembled;
         ovld_d  = 1'b1;
      end else if (out_take) begin
         ovld_d  = 1'b0;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= 3'd0;
         coll_q  <= 8'd0;
         obyte_q <= 8'd0;
         ovld_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         coll_q  <= coll_d;
         obyte_q <= obyte_d;
         ovld_q  <= ovld_d;
      end
   end

   assign out_byte  = obyte_q;
   assign out_valid = ovld_q;
   assign bit_count = cnt_q;

endmodule
